oram_frontend_arbiter: RTL

Round-robin arbiter that shares the single PathORamTop front-end interface among NumReq requesters (e.g. instruction fetch, data cache, DMA).
A winning requester holds the grant for one full transaction: command handshake, then FEORAMBChunks data chunks.
Update/Append stream data in; Read/ReadRmv stream data out.
It sits directly in front of PathORamTop and replaces the single-master command and data ports.

---
 rtl/oram_frontend_arbiter_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/oram_frontend_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/oram_frontend_arbiter_pkg.sv
// Shared constants for the ORAM front-end arbiter: backend command encodings and a log2 helper.
package oram_frontend_arbiter_pkg;

    localparam logic [1:0] BECMD_Update  = 2'd0;
    localparam logic [1:0] BECMD_Append  = 2'd1;
    localparam logic [1:0] BECMD_Read    = 2'd2;
    localparam logic [1:0] BECMD_ReadRmv = 2'd3;

    // Ceiling log2, matching the legacy `log2 macro.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = 1
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] grantIdx,
    output logic                anyGrant
);

    function automatic int unsigned wrapIdx(input int unsigned base, input int unsigned offset);
        int unsigned sum;
        sum = base + offset;
        return (sum >= NumReq) ? sum - NumReq : sum;
    endfunction

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                if (!anyGrant && (k == wrapIdx(32'(ptr), i)) && req[k]) begin
                    anyGrant = 1'b1;
                    grant[k] = 1'b1;
                    grantIdx = IdxWidth'(k);
                end
            end
        end
    end

endmodule

// File: rtl/oram_frontend_arbiter.sv
// Shares the single PathORamTop front-end among NumReq requesters; a grant lasts one
// full transaction (command handshake plus FEORAMBChunks data chunks).
module oram_frontend_arbiter
    import oram_frontend_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned ORAMU    = 32,
    parameter int unsigned ORAMB    = 512,
    parameter int unsigned FEDWidth = 32,
    localparam int unsigned FEORAMBChunks = ORAMB / FEDWidth,
    localparam int unsigned IdxWidth      = (NumReq > 1) ? log2(NumReq) : 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [2*NumReq-1:0]        ReqCmd,
    input  logic [ORAMU*NumReq-1:0]    ReqPAddr,
    input  logic [NumReq-1:0]          ReqCmdValid,
    output logic [NumReq-1:0]          ReqCmdReady,
    input  logic [FEDWidth*NumReq-1:0] ReqDataIn,
    input  logic [NumReq-1:0]          ReqDataInValid,
    output logic [NumReq-1:0]          ReqDataInReady,
    output logic [FEDWidth-1:0]        ReqDataOut,
    output logic [NumReq-1:0]          ReqDataOutValid,
    input  logic [NumReq-1:0]          ReqDataOutReady,
    output logic [1:0]                 Cmd,
    output logic [ORAMU-1:0]           PAddr,
    output logic                       CmdValid,
    input  logic                       CmdReady,
    output logic [FEDWidth-1:0]        DataIn,
    output logic                       DataInValid,
    input  logic                       DataInReady,
    input  logic [FEDWidth-1:0]        DataOut,
    input  logic                       DataOutValid,
    output logic                       DataOutReady,
    output logic [IdxWidth-1:0]        GrantIdx,
    output logic                       Busy
);

    localparam int unsigned CntWidth = log2(FEORAMBChunks) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCmd   = 2'd1;
    localparam logic [1:0] StWData = 2'd2;
    localparam logic [1:0] StRData = 2'd3;

    logic [1:0]          stateQ, stateD;
    logic [1:0]          cmdQ, cmdD;
    logic [ORAMU-1:0]    pAddrQ, pAddrD;
    logic [IdxWidth-1:0] grantQ, grantD;
    logic [IdxWidth-1:0] ptrQ, ptrD;
    logic [CntWidth-1:0] cntQ, cntD;

    logic [NumReq-1:0]   arbGrant;
    logic [IdxWidth-1:0] arbIdx;
    logic                arbAny;
    logic [1:0]          arbCmd;
    logic [ORAMU-1:0]    arbAddr;

    logic [NumReq-1:0]   ownerOneHot;
    logic [FEDWidth-1:0] selDataIn;
    logic                selDataInValid;
    logic                selDataOutReady;
    logic                inWData, inRData, wHs, rHs, lastChunk;

    rr_arbiter #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_arbiter (
        .req      (ReqCmdValid),
        .ptr      (ptrQ),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyGrant (arbAny)
    );

    always_comb begin
        arbCmd  = '0;
        arbAddr = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (arbGrant[k]) begin
                arbCmd  = ReqCmd[2*k +: 2];
                arbAddr = ReqPAddr[k*ORAMU +: ORAMU];
            end
        end
    end

    // Per-requester slices of the current owner's data-path signals.
    always_comb begin
        ownerOneHot     = '0;
        selDataIn       = '0;
        selDataInValid  = 1'b0;
        selDataOutReady = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (grantQ == IdxWidth'(k)) begin
                ownerOneHot[k]  = 1'b1;
                selDataIn       = ReqDataIn[k*FEDWidth +: FEDWidth];
                selDataInValid  = ReqDataInValid[k];
                selDataOutReady = ReqDataOutReady[k];
            end
        end
    end

    assign inWData   = (stateQ == StWData);
    assign inRData   = (stateQ == StRData);
    assign wHs       = DataInValid & DataInReady;
    assign rHs       = DataOutValid & DataOutReady;
    assign lastChunk = (cntQ == CntWidth'(FEORAMBChunks - 1));

    assign ReqCmdReady     = (stateQ == StIdle) ? arbGrant : '0;
    assign CmdValid        = (stateQ == StCmd);
    assign Cmd             = cmdQ;
    assign PAddr           = pAddrQ;
    assign DataIn          = inWData ? selDataIn : '0;
    assign DataInValid     = inWData & selDataInValid;
    assign ReqDataInReady  = {NumReq{inWData & DataInReady}} & ownerOneHot;
    assign ReqDataOut      = inRData ? DataOut : '0;
    assign ReqDataOutValid = {NumReq{inRData & DataOutValid}} & ownerOneHot;
    assign DataOutReady    = inRData & selDataOutReady;
    assign GrantIdx        = grantQ;
    assign Busy            = (stateQ != StIdle);

    always_comb begin
        stateD = stateQ;
        cmdD   = cmdQ;
        pAddrD = pAddrQ;
        grantD = grantQ;
        ptrD   = ptrQ;
        cntD   = cntQ;
        case (stateQ)
            StIdle: begin
                if (arbAny) begin
                    stateD = StCmd;
                    cmdD   = arbCmd;
                    pAddrD = arbAddr;
                    grantD = arbIdx;
                    ptrD   = (arbIdx == IdxWidth'(NumReq - 1)) ? '0 : arbIdx + IdxWidth'(1);
                end
            end
            StCmd: begin
                if (CmdReady) begin
                    cntD   = '0;
                    stateD = (cmdQ == BECMD_Update || cmdQ == BECMD_Append) ? StWData : StRData;
                end
            end
            StWData: begin
                if (wHs) begin
                    if (lastChunk) begin
                        stateD = StIdle;
                        cntD   = '0;
                    end else begin
                        cntD = cntQ + CntWidth'(1);
                    end
                end
            end
            StRData: begin
                if (rHs) begin
                    if (lastChunk) begin
                        stateD = StIdle;
                        cntD   = '0;
                    end else begin
                        cntD = cntQ + CntWidth'(1);
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateQ <= StIdle;
            cmdQ   <= '0;
            pAddrQ <= '0;
            grantQ <= '0;
            ptrQ   <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cmdQ   <= cmdD;
            pAddrQ <= pAddrD;
            grantQ <= grantD;
            ptrQ   <= ptrD;
            cntQ   <= cntD;
        end
    end

endmodule
